// File: rtl/rsign_pkg.sv
// Shared types and constants for the streaming RSign binariser.
package rsign_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } rsign_state_e;

  localparam logic MODE_RELOAD = 1'b0;
  localparam logic MODE_CALC   = 1'b1;

endpackage

// File: rtl/rsign_lane.sv
// One channel: threshold register plus WIN signed comparators.
module rsign_lane #(
  parameter int WIN    = 9,
  parameter int DATA_W = 16,
  parameter int PARA_W = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [PARA_W-1:0]            th_in,
  input  logic                         cmp_ge,
  input  logic [WIN-1:0][DATA_W-1:0]   x,
  output logic [WIN-1:0]               bits
);

  localparam int MW = (DATA_W > PARA_W) ? DATA_W : PARA_W;

  // Thresholds are deliberately not reset; nothing reads them before a full load.
  logic signed [PARA_W-1:0] th;
  logic signed [MW-1:0]     ts;

  always_ff @(posedge clk) begin
    if (we) th <= th_in;
  end

  assign ts = MW'(th);

  for (genvar t = 0; t < WIN; t++) begin : g_tap
    logic signed [DATA_W-1:0] xv;
    logic signed [MW-1:0]     xs;
    assign xv      = x[t];
    assign xs      = MW'(xv);
    assign bits[t] = cmp_ge ? (xs >= ts) : (xs > ts);
  end

endmodule

// File: rtl/rsign_stream.sv
// Streaming RSign binariser: threshold bank loader, per-beat compare, output register.
module rsign_stream
  import rsign_pkg::*;
#(
  parameter int CH     = 256,
  parameter int WIN    = 9,
  parameter int DATA_W = 16,
  parameter int PARA_W = 16,
  parameter int LANES  = 16,
  parameter int SB_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     para_valid,
  output logic                     para_ready,
  input  logic [LANES*PARA_W-1:0]  para_in,
  output logic                     para_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*WIN*DATA_W-1:0] data_in,
  input  logic                     cmp_ge,
  input  logic [SB_W-1:0]          sb_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*WIN-1:0]        data_out,
  output logic [SB_W-1:0]          sb_out
);

  localparam int NB    = CH / LANES;
  localparam int PTR_W = (NB > 1) ? $clog2(NB) : 1;

  rsign_state_e           state, state_n;
  logic [PTR_W-1:0]       ptr, ptr_n;
  logic                   p_acc, d_acc;
  logic [CH-1:0][WIN-1:0] bits;

  assign para_ready = (mode == MODE_RELOAD);
  assign para_done  = (state == ARMED);
  assign in_ready   = (mode == MODE_CALC) && (state == ARMED) && (!out_valid || out_ready);
  assign p_acc      = para_valid && para_ready;
  assign d_acc      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // ptr is 0 whenever ARMED, so a beat arriving then naturally restarts as beat 0.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    if (p_acc) begin
      if (ptr == PTR_W'(NB - 1)) begin
        ptr_n   = '0;
        state_n = ARMED;
      end else begin
        ptr_n   = ptr + 1'b1;
        state_n = LOAD;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    rsign_lane #(
      .WIN    (WIN),
      .DATA_W (DATA_W),
      .PARA_W (PARA_W)
    ) u_lane (
      .clk    (clk),
      .we     (p_acc && (ptr == PTR_W'(c / LANES))),
      .th_in  (para_in[(c % LANES)*PARA_W +: PARA_W]),
      .cmp_ge (cmp_ge),
      .x      (data_in[c*WIN*DATA_W +: WIN*DATA_W]),
      .bits   (bits[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sb_out    <= '0;
    end else if (d_acc) begin
      out_valid <= 1'b1;
      data_out  <= bits;
      sb_out    <= sb_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rsign_stream.md
# rsign_stream

Parametrised streaming RSign binariser, the successor of the fixed per-layer RSign stages. It holds a per-channel signed threshold bank, loaded in bursts of LANES thresholds through a valid/ready port, and binarises a CH x WIN window of signed activations per accepted beat. The compare mode (strict or non-strict) is selectable per beat, and a sideband tag (macro select) travels aligned with the data. It sits between the accumulate/BN stage and the next binary conv macro.

## Interface
- CH, 256: channels (feature-map depth); CH % LANES == 0
- WIN, 9: taps per channel (3x3 window)
- DATA_W, 16: signed activation width
- PARA_W, 16: signed threshold width
- LANES, 16: thresholds per load beat
- SB_W, 2: sideband width

- clk  in  1  system clock
- rst  in  1  reset; one clock, reset synchronous and active-high
- mode  in  1  0 = reload parameters, 1 = calculate
- para_valid  in  1  threshold beat valid
- para_ready  out  1  threshold beat accepted when both high
- para_in  in  LANES*PARA_W  lane k = threshold of channel ptr*LANES+k
- para_done  out  1  bank fully loaded (state ARMED)
- in_valid  in  1  data beat valid
- in_ready  out  1  data beat accepted when both high
- data_in  in  CH*WIN*DATA_W  channel-major, tap-minor, signed
- cmp_ge  in  1  per beat: 1 = (x >= th), 0 = (x > th)
- sb_in  in  SB_W  sideband, captured with data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- data_out  out  CH*WIN  bit [c*WIN+t] = binarised tap t of channel c
- sb_out  out  SB_W  sideband aligned with data_out

## Operation
- FSM states: EMPTY, LOAD, ARMED. Reset → EMPTY, ptr = 0.
- para_ready = (mode == 0) in every state. A beat is accepted when para_valid && para_ready.
- Accepted beat: write lanes to channels ptr*LANES .. ptr*LANES+LANES-1.
  - If ptr == CH/LANES-1: ptr ← 0, state → ARMED.
  - Otherwise: ptr++, state → LOAD.
- Accepted beat in ARMED: restarts the load. The beat is written as beat 0, ptr ← 1, state → LOAD, and para_done drops in the next cycle.
- mode = 1 during LOAD: loading pauses, ptr is held, and no data is accepted.
- in_ready = (mode == 1) && ARMED && (!out_valid || out_ready).
- Accepted data beat: for every c and t, compute a signed compare of data_in[c][t] against th[c] using the cmp_ge rule. The result is registered into data_out, and sb_in is registered into sb_out.
- Output register:
  - out_valid ← 1 on accept.
  - out_valid ← 0 on out_ready && !accept.
  - data_out and sb_out are held stable while out_valid && !out_ready.
- A beat already in the output register drains normally after mode returns to 0. It keeps the bits computed with the old thresholds.
- Thresholds are not reset. data_out is undefined-free because no beat is accepted before ARMED.
- Width rule: the comparison is between the sign-extended max(DATA_W, PARA_W)-bit values. Equality matters only when cmp_ge = 1.

## Timing
- Reset values:
  - para_done 0, in_ready 0, para_ready = (mode == 0).
  - out_valid 0, data_out all 0, sb_out 0.
- Reset has priority over every other event in the same cycle. Reset during LOAD discards the partial bank and returns to EMPTY.
- Load latency: para_done rises the cycle after the final beat is accepted. The minimum full load is CH/LANES cycles.
- Data latency: 1 cycle from accept to out_valid. Throughput is 1 beat/cycle while out_ready stays high.
- Simultaneous out_ready and accept: the register is refilled, and out_valid stays 1.
- para_ready, para_done and in_ready are combinational only from mode, state and out_valid/out_ready. There is no path from para_valid or in_valid.

## Structure
- Package rsign_pkg holds:
  - enum rsign_state_e {EMPTY, LOAD, ARMED}
  - constants MODE_RELOAD = 1'b0, MODE_CALC = 1'b1
- Sub-module rsign_lane: one channel's WIN comparators plus its threshold register, with a write enable and the cmp_ge select. It is generated CH times.
- The top level holds the FSM, ptr counter, handshakes and output register.

## Test plan
- Load, CH=32, LANES=8, mode 0: 4 beats with thresholds = channel index → para_done rises exactly 1 cycle after the 4th accept; in_ready stays 0 until mode = 1.
- Compare, all taps of ch 5 = {4,5,6,…}, th[5] = 5:
  - cmp_ge = 0 → bits 0,0,1.
  - cmp_ge = 1 → 0,1,1.
  - Negative case: -3 vs th = -4 → 1.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1 → no beat lost or duplicated, data_out/sb_out stable while stalled, sb_out tags in order.
- Mode = 1 after 2 of 4 load beats → in_ready 0; mode back to 0 resumes at ptr = 2; the bank is correct after 2 more beats.
- Reload from ARMED: a new beat clears para_done next cycle, and the old output beat still drains with the old results.
- rst asserted mid-load and with out_valid = 1 → next cycle out_valid 0, data_out 0, state EMPTY; a full reload is required.
